seq_det_controller: RTL
=======================

// Module: seq_det_controller
// PURPOSE
//  Programmable serial pattern-detect controller. Accepts a pattern configuration over a
//  valid/ready handshake and arms detection on start. Scans a qualified serial bit stream,
//  in overlapping or non-overlapping mode, and counts matches up to a target, then reports done.
//  Sits between the register/config host and the serial bit source; replaces per-pattern FSMs.
// PARAMETERS
//  MAXLEN  8   maximum pattern length in bits (>=2)
//  LW      4   width of cfg_len; must hold MAXLEN
//  CW      8   width of match counter and cfg_target
// PORTS
//  clk           in   1       clock, all logic on rising edge
//  rst           in   1       synchronous, active-high reset
//  cfg_valid     in   1       config offer
//  cfg_ready     out  1       config accept window (IDLE or DONE)
//  cfg_pattern   in   MAXLEN  pattern; bit[len-1] = first bit received, bit[0] = last
//  cfg_len       in   LW      pattern length, legal 1..MAXLEN
//  cfg_overlap   in   1       1 = overlapping detection, 0 = non-overlapping
//  cfg_target    in   CW      match count that ends the run; 0 = free-run
//  start         in   1       arm/run request (IDLE or DONE, needs valid config)
//  abort         in   1       stop run, return to IDLE
//  bit_valid     in   1       qualifies bit_in this cycle
//  bit_in        in   1       serial data
//  match_pulse   out  1       1-cycle pulse, registered, cycle after matching bit
//  match_count   out  CW      matches in current run, saturating
//  busy          out  1       high in RUN
//  done          out  1       high in DONE
//  cfg_err       out  1       sticky: last config offer was illegal
// BEHAVIOUR
//  Reset: state=IDLE, cfg_ready=1, match_pulse=0, match_count=0, busy=0, done=0, cfg_err=0,
//   cfg_ok=0, history=0, fill=0.
//  States: IDLE -> RUN on start&cfg_ok. RUN -> DONE when count reaches nonzero target.
//   RUN -> IDLE on abort. DONE -> RUN on start. DONE -> IDLE on abort.
//  Config: accepted on cfg_valid&cfg_ready. cfg_len==0 or >MAXLEN -> cfg_err=1, cfg_ok=0,
//   stored config unchanged. Legal -> latch all cfg_* fields, cfg_err=0, cfg_ok=1.
//  start with cfg_ok=0 is ignored. start in RUN is ignored. cfg_valid outside IDLE/DONE is
//   not accepted (cfg_ready=0).
//  Entering RUN: history, fill and match_count clear; done drops the same edge.
//  RUN, bit_valid=1: history <= {history,bit_in}. fill <= min(fill+1, MAXLEN).
//   Match = (fill_next >= len) && (history_next[len-1:0] == pattern[len-1:0]).
//  On match:
//   - match_pulse=1 next cycle.
//   - match_count+1, saturating at 2^CW-1.
//   - non-overlap mode: fill <= 0, so the next match needs len fresh bits.
//  Target: if target!=0 and the incremented count == target, go to DONE the same edge;
//   further bits are ignored. bit_valid=0 leaves history and fill untouched.
//  Simultaneous events:
//   - abort beats match: no pulse, no count, -> IDLE, match_count holds its value.
//   - abort beats start in IDLE/DONE.
//   - cfg accept and start in the same cycle: start uses the OLD config; the new config
//     applies from the next run.
//  rst mid-run: immediate return to reset values; the config must be re-sent.
//  Latency: bit accepted at edge N -> match_pulse high during cycle N+1 and count updated
//   at edge N. No combinational path from bit_in to any output.
// STRUCTURE
//  Package seq_det_pkg: state enum (IDLE, RUN, DONE), default MAXLEN/LW/CW constants.
//  Sub-module seq_det_matcher: history shift register + fill counter + masked compare.
//   Inputs: shift, clear, len, pattern, overlap. Output: hit.
//  Top level holds the FSM, config registers, counter and output registers.
// TESTING
//  1 Config 1011/len4/non-overlap/target0, start, stream 1,0,1,1,0,1,1
//    -> one pulse after 4th bit, count=1.
//  2 Same stream, overlap=1 -> pulses after bits 4 and 7, count=2.
//  3 cfg_len=0 then cfg_len=9 (MAXLEN=8) -> cfg_err=1 each time, start ignored, busy stays 0.
//  4 Pattern 11/len2/overlap/target3, stream of 1s -> pulses after bits 2,3,4; done=1;
//    5th bit makes no pulse.
//  5 abort in the same cycle as the matching bit -> no pulse, state IDLE, count unchanged.
//    rst mid-run -> all outputs at reset values.
//  6 Gaps in bit_valid inside 1011 -> match still after the 4th valid bit.
//    DONE then start -> count clears and the run restarts.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the programmable serial pattern-detect controller.
package seq_det_pkg;

  localparam int unsigned MaxLenDef = 8;
  localparam int unsigned LenWDef   = 4;
  localparam int unsigned CntWDef   = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // A pattern length is usable only if it is 1..max_len.
  function automatic logic len_legal(input int unsigned len, input int unsigned max_len);
    return (len != 0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_det_if.sv
// Config, control, serial-stream and status signals of the pattern-detect controller.
interface seq_det_if
  import seq_det_pkg::*;
#(
  parameter int unsigned MAXLEN = MaxLenDef,
  parameter int unsigned LW     = LenWDef,
  parameter int unsigned CW     = CntWDef
) ();

  logic              cfg_valid;
  logic              cfg_ready;
  logic [MAXLEN-1:0] cfg_pattern;
  logic [LW-1:0]     cfg_len;
  logic              cfg_overlap;
  logic [CW-1:0]     cfg_target;
  logic              start;
  logic              abort;
  logic              bit_valid;
  logic              bit_in;
  logic              match_pulse;
  logic [CW-1:0]     match_count;
  logic              busy;
  logic              done;
  logic              cfg_err;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    output start, abort, bit_valid, bit_in,
    input  cfg_ready, match_pulse, match_count, busy, done, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    input  start, abort, bit_valid, bit_in,
    output cfg_ready, match_pulse, match_count, busy, done, cfg_err
  );

endinterface

// File: rtl/seq_det_matcher.sv
// History shift register, fill counter and length-masked compare against the pattern.
module seq_det_matcher
  import seq_det_pkg::*;
#(
  parameter int unsigned MAXLEN = MaxLenDef,
  parameter int unsigned LW     = LenWDef
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift,
  input  logic              clear,
  input  logic              bit_in,
  input  logic [LW-1:0]     len,
  input  logic [MAXLEN-1:0] pattern,
  input  logic              overlap,
  output logic              hit
);

  logic [MAXLEN-1:0] history_q, history_d, hist_next, mask;
  logic [LW-1:0]     fill_q, fill_d, fill_next;

  always_comb begin
    hist_next = {history_q[MAXLEN-2:0], bit_in};
    fill_next = (fill_q >= LW'(MAXLEN)) ? LW'(MAXLEN) : fill_q + 1'b1;
    for (int i = 0; i < int'(MAXLEN); i++) begin
      mask[i] = (i < int'(len));
    end
    hit = shift && (fill_next >= len) && (((hist_next ^ pattern) & mask) == '0);

    history_d = history_q;
    fill_d    = fill_q;
    if (clear) begin
      history_d = '0;
      fill_d    = '0;
    end else if (shift) begin
      history_d = hist_next;
      // Non-overlapping mode needs len fresh bits after each match.
      fill_d    = (hit && !overlap) ? '0 : fill_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      history_q <= '0;
      fill_q    <= '0;
    end else begin
      history_q <= history_d;
      fill_q    <= fill_d;
    end
  end

endmodule

// File: rtl/seq_det_controller.sv
// Pattern-detect controller: config registers, IDLE/RUN/DONE FSM, match counter, outputs.
module seq_det_controller
  import seq_det_pkg::*;
#(
  parameter int unsigned MAXLEN = MaxLenDef,
  parameter int unsigned LW     = LenWDef,
  parameter int unsigned CW     = CntWDef
) (
  input logic      clk,
  input logic      rst,
  seq_det_if.slave bus
);

  state_e            state_q, state_d;
  logic [MAXLEN-1:0] cfg_pattern_q, cfg_pattern_d, run_pattern_q, run_pattern_d;
  logic [LW-1:0]     cfg_len_q, cfg_len_d, run_len_q, run_len_d;
  logic              cfg_overlap_q, cfg_overlap_d, run_overlap_q, run_overlap_d;
  logic [CW-1:0]     cfg_target_q, cfg_target_d, run_target_q, run_target_d;
  logic              cfg_ok_q, cfg_ok_d, cfg_err_q, cfg_err_d;
  logic [CW-1:0]     count_q, count_d;
  logic              pulse_q, pulse_d;
  logic              cfg_ready, cfg_accept, start_run, shift, hit;

  assign cfg_ready  = (state_q == StIdle) || (state_q == StDone);
  assign cfg_accept = bus.cfg_valid && cfg_ready;
  // Uses cfg_ok_q, so a config accepted this same cycle cannot arm this run.
  assign start_run  = cfg_ready && bus.start && !bus.abort && cfg_ok_q;
  assign shift      = (state_q == StRun) && bus.bit_valid && !bus.abort;

  seq_det_matcher #(
    .MAXLEN(MAXLEN),
    .LW    (LW)
  ) u_matcher (
    .clk    (clk),
    .rst    (rst),
    .shift  (shift),
    .clear  (start_run),
    .bit_in (bus.bit_in),
    .len    (run_len_q),
    .pattern(run_pattern_q),
    .overlap(run_overlap_q),
    .hit    (hit)
  );

  always_comb begin
    state_d       = state_q;
    cfg_pattern_d = cfg_pattern_q;
    cfg_len_d     = cfg_len_q;
    cfg_overlap_d = cfg_overlap_q;
    cfg_target_d  = cfg_target_q;
    cfg_ok_d      = cfg_ok_q;
    cfg_err_d     = cfg_err_q;
    run_pattern_d = run_pattern_q;
    run_len_d     = run_len_q;
    run_overlap_d = run_overlap_q;
    run_target_d  = run_target_q;
    count_d       = count_q;
    pulse_d       = 1'b0;

    if (cfg_accept) begin
      if (len_legal(32'(bus.cfg_len), MAXLEN)) begin
        cfg_pattern_d = bus.cfg_pattern;
        cfg_len_d     = bus.cfg_len;
        cfg_overlap_d = bus.cfg_overlap;
        cfg_target_d  = bus.cfg_target;
        cfg_ok_d      = 1'b1;
        cfg_err_d     = 1'b0;
      end else begin
        cfg_ok_d  = 1'b0;
        cfg_err_d = 1'b1;
      end
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (start_run) begin
          state_d       = StRun;
          count_d       = '0;
          run_pattern_d = cfg_pattern_q;
          run_len_d     = cfg_len_q;
          run_overlap_d = cfg_overlap_q;
          run_target_d  = cfg_target_q;
        end
      end
      StRun: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (hit) begin
          pulse_d = 1'b1;
          count_d = (count_q == '1) ? count_q : count_q + 1'b1;
          if ((run_target_q != '0) && (count_d == run_target_q)) begin
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      cfg_pattern_q <= '0;
      cfg_len_q     <= '0;
      cfg_overlap_q <= 1'b0;
      cfg_target_q  <= '0;
      cfg_ok_q      <= 1'b0;
      cfg_err_q     <= 1'b0;
      run_pattern_q <= '0;
      run_len_q     <= '0;
      run_overlap_q <= 1'b0;
      run_target_q  <= '0;
      count_q       <= '0;
      pulse_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cfg_pattern_q <= cfg_pattern_d;
      cfg_len_q     <= cfg_len_d;
      cfg_overlap_q <= cfg_overlap_d;
      cfg_target_q  <= cfg_target_d;
      cfg_ok_q      <= cfg_ok_d;
      cfg_err_q     <= cfg_err_d;
      run_pattern_q <= run_pattern_d;
      run_len_q     <= run_len_d;
      run_overlap_q <= run_overlap_d;
      run_target_q  <= run_target_d;
      count_q       <= count_d;
      pulse_q       <= pulse_d;
    end
  end

  assign bus.cfg_ready   = cfg_ready;
  assign bus.match_pulse = pulse_q;
  assign bus.match_count = count_q;
  assign bus.busy        = (state_q == StRun);
  assign bus.done        = (state_q == StDone);
  assign bus.cfg_err     = cfg_err_q;

endmodule
